trace_stage_arbiter: RTL and testbench

- Merges completed trace elements from the IF, ID and EX trackers into one ordered stream for the downstream trace sink.
- Each tracker delivers an element as a single-cycle `*_data_ready` pulse. This block captures every pulse in a per-source holding slot and arbitrates the slots round-robin into a first-word-fall-through FIFO.
- The FIFO drains over a valid/ready handshake.
- Elements that arrive while their source slot is still occupied are dropped and counted.

---
 rtl/trace_stage_arbiter.sv | 141 ++++++++++++++
 tb/tb_trace_stage_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_stage_arbiter.sv
// rtl/trace_stage_arbiter.sv - merges IF/ID/EX trace elements into one ordered FWFT stream
module trace_stage_arbiter #(
  parameter int TRACE_W    = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          if_data_ready,
  input  logic [TRACE_W-1:0]            if_data_in,
  input  logic                          id_data_ready,
  input  logic [TRACE_W-1:0]            id_data_in,
  input  logic                          ex_data_ready,
  input  logic [TRACE_W-1:0]            ex_data_in,
  output logic [TRACE_W-1:0]            trace_o,
  output logic                          trace_valid_o,
  input  logic                          trace_ready_i,
  output logic [2:0]                    slot_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [CNT_W-1:0]              drop_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [2:0]         slot_full;
  logic [TRACE_W-1:0] slot_data [3];
  logic [2:0]         src_ready;
  logic [TRACE_W-1:0] src_data [3];
  logic [TRACE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      level;
  logic [1:0]         rr;
  logic               overflow;
  logic [CNT_W-1:0]   drop_count;

  logic               pop;
  logic               push_ok;
  logic               grant_valid;
  logic [1:0]         grant_idx;
  logic [2:0]         grant_oh;
  logic [2:0]         cand;
  logic [2:0]         load;
  logic [2:0]         drop;
  logic [1:0]         drop_n;
  logic [CNT_W+1:0]   drop_sum;

  assign src_ready   = {ex_data_ready, id_data_ready, if_data_ready};
  assign src_data[0] = if_data_in;
  assign src_data[1] = id_data_in;
  assign src_data[2] = ex_data_in;

  assign trace_valid_o = (level != '0);
  assign pop           = trace_valid_o && trace_ready_i;
  assign push_ok       = (level < DEPTH_L) || pop;

  // Scan from the farthest candidate back to rr so the nearest full slot wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 3'd0;
    if (push_ok) begin
      for (int k = 2; k >= 0; k--) begin
        cand = {1'b0, rr} + 3'(k);
        if (cand >= 3'd3) cand = cand - 3'd3;
        if (slot_full[cand[1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[1:0];
        end
      end
    end
  end

  assign grant_oh = grant_valid ? (3'b001 << grant_idx) : 3'b000;

  always_comb begin
    load = 3'b000;
    drop = 3'b000;
    for (int i = 0; i < 3; i++) begin
      load[i] = src_ready[i] && (!slot_full[i] || grant_oh[i]);
      drop[i] = src_ready[i] && slot_full[i] && !grant_oh[i];
    end
  end

  assign drop_n   = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
  assign drop_sum = {2'b00, drop_count} + {{CNT_W{1'b0}}, drop_n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_full  <= 3'b000;
      for (int i = 0; i < 3; i++) slot_data[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rr         <= 2'd0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush_i) begin
      slot_full <= 3'b000;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rr        <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load[i]) begin
          slot_full[i] <= 1'b1;
          slot_data[i] <= src_data[i];
        end else if (grant_oh[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
      if (grant_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (grant_valid && !pop)      level <= level + 1'b1;
      else if (!grant_valid && pop) level <= level - 1'b1;
      if (|drop) begin
        overflow   <= 1'b1;
        drop_count <= (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end
    end
  end

  // Storage needs no reset: nothing is visible until the level says so.
  always_ff @(posedge clk) begin
    if (rst && !flush_i && grant_valid) mem[wr_ptr] <= slot_data[grant_idx];
  end

  assign trace_o      = trace_valid_o ? mem[rd_ptr] : '0;
  assign slot_full_o  = slot_full;
  assign fifo_level_o = level;
  assign overflow_o   = overflow;
  assign drop_count_o = drop_count;
endmodule

// File: tb/tb_trace_stage_arbiter.sv
// tb/tb_trace_stage_arbiter.sv - directed and randomized checks of trace_stage_arbiter against a queue model
module tb_trace_stage_arbiter;
  localparam int TW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_i = 1'b0;
  logic          if_data_ready = 1'b0;
  logic [TW-1:0] if_data_in = '0;
  logic          id_data_ready = 1'b0;
  logic [TW-1:0] id_data_in = '0;
  logic          ex_data_ready = 1'b0;
  logic [TW-1:0] ex_data_in = '0;
  logic          trace_ready_i = 1'b0;
  logic [TW-1:0] trace_o;
  logic          trace_valid_o;
  logic [2:0]    slot_full_o;
  logic [LW-1:0] fifo_level_o;
  logic          overflow_o;
  logic [CW-1:0] drop_count_o;

  always #5 clk = ~clk;

  trace_stage_arbiter #(.TRACE_W(TW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_data_ready(if_data_ready), .if_data_in(if_data_in),
    .id_data_ready(id_data_ready), .id_data_in(id_data_in),
    .ex_data_ready(ex_data_ready), .ex_data_in(ex_data_in),
    .trace_o(trace_o), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .slot_full_o(slot_full_o), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o), .drop_count_o(drop_count_o)
  );

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] m_q[$];
  bit            m_full[3];
  logic [TW-1:0] m_slot[3];
  int            m_rr;
  int            m_drops;
  bit            m_ovf;
  logic [TW-1:0] got[$];
  logic [TW-1:0] exp_list[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: slots as a flag array, FIFO as a queue, round robin as an integer.
  task automatic model_step();
    bit            rdy[3];
    logic [TW-1:0] din[3];
    bit            pop;
    bit            can;
    int            g;
    int            n;
    rdy = '{if_data_ready, id_data_ready, ex_data_ready};
    din = '{if_data_in, id_data_in, ex_data_in};
    if (!rst) begin
      m_q.delete();
      m_full = '{0, 0, 0};
      m_rr = 0;
      m_drops = 0;
      m_ovf = 0;
    end else if (flush_i) begin
      m_q.delete();
      m_full = '{0, 0, 0};
      m_rr = 0;
    end else begin
      pop = (m_q.size() > 0) && trace_ready_i;
      can = (m_q.size() < DEPTH) || pop;
      g = -1;
      if (can) begin
        for (int k = 0; k < 3; k++) begin
          if (g < 0 && m_full[(m_rr + k) % 3]) g = (m_rr + k) % 3;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back(m_slot[g]);
        m_full[g] = 0;
        m_rr = (g + 1) % 3;
      end
      n = 0;
      for (int i = 0; i < 3; i++) begin
        if (rdy[i]) begin
          if (m_full[i]) n++;
          else begin
            m_full[i] = 1;
            m_slot[i] = din[i];
          end
        end
      end
      if (n > 0) m_ovf = 1;
      m_drops = (m_drops + n > CMAX) ? CMAX : m_drops + n;
    end
  endtask

  task automatic check_all();
    chk("level", 64'(fifo_level_o), 64'(m_q.size()));
    chk("valid", 64'(trace_valid_o), 64'(m_q.size() != 0));
    if (m_q.size() != 0) chk("data", 64'(trace_o), 64'(m_q[0]));
    chk("slots", 64'(slot_full_o), 64'({m_full[2], m_full[1], m_full[0]}));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("drops", 64'(drop_count_o), 64'(m_drops));
  endtask

  task automatic tick();
    if (rst && !flush_i && trace_valid_o && trace_ready_i) got.push_back(trace_o);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if_data_ready = 1'b0;
    id_data_ready = 1'b0;
    ex_data_ready = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [TW-1:0] d);
    case (i)
      0: begin if_data_ready = 1'b1; if_data_in = d; end
      1: begin id_data_ready = 1'b1; id_data_in = d; end
      default: begin ex_data_ready = 1'b1; ex_data_in = d; end
    endcase
  endtask

  task automatic restart();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    got.delete();
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_list.size()));
    for (int i = 0; i < exp_list.size(); i++) begin
      if (i < got.size()) chk(tag, 64'(got[i]), 64'(exp_list[i]));
    end
  endtask

  initial begin
    int pct;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_valid", 64'(trace_valid_o), 64'(0));
    chk("rst_data", 64'(trace_o), 64'(0));
    chk("rst_level", 64'(fifo_level_o), 64'(0));
    chk("rst_slots", 64'(slot_full_o), 64'(0));
    chk("rst_ovf", 64'(overflow_o), 64'(0));
    chk("rst_drops", 64'(drop_count_o), 64'(0));
    rst = 1'b1;

    set_src(0, 32'h11);
    tick();
    chk("lat1_valid", 64'(trace_valid_o), 64'(0));
    chk("lat1_slots", 64'(slot_full_o), 64'(3'b001));
    tick();
    chk("lat2_valid", 64'(trace_valid_o), 64'(1));
    chk("lat2_data", 64'(trace_o), 64'(32'h11));
    chk("lat2_level", 64'(fifo_level_o), 64'(1));

    restart();
    trace_ready_i = 1'b1;
    set_src(0, 32'hA1); set_src(1, 32'hB2); set_src(2, 32'hC3);
    tick();
    repeat (4) tick();
    set_src(0, 32'hD4); set_src(1, 32'hE5); set_src(2, 32'hF6);
    tick();
    repeat (4) tick();
    exp_list = '{32'hA1, 32'hB2, 32'hC3, 32'hD4, 32'hE5, 32'hF6};
    chk_stream("rr_order");

    restart();
    trace_ready_i = 1'b0;
    for (int v = 1; v <= 11; v++) begin
      set_src(2, TW'(v));
      tick();
    end
    tick();
    chk("full_level", 64'(fifo_level_o), 64'(8));
    chk("full_slots", 64'(slot_full_o), 64'(3'b100));
    chk("full_drops", 64'(drop_count_o), 64'(2));
    chk("full_ovf", 64'(overflow_o), 64'(1));
    trace_ready_i = 1'b1;
    for (int v = 0; v < 5; v++) begin
      set_src(1, TW'(32'h21 + v));
      tick();
      chk("pp_level", 64'(fifo_level_o), 64'(8));
      chk("pp_drops", 64'(drop_count_o), 64'(2));
    end
    repeat (16) tick();
    exp_list = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9,
                 32'h21, 32'h22, 32'h23, 32'h24, 32'h25};
    chk_stream("full_order");

    restart();
    trace_ready_i = 1'b0;
    set_src(0, 32'h1); set_src(1, 32'h2); set_src(2, 32'h3);
    tick();
    set_src(2, 32'h9);
    tick();
    tick();
    tick();
    set_src(0, 32'h4); set_src(1, 32'h5);
    tick();
    chk("preflush_level", 64'(fifo_level_o), 64'(3));
    chk("preflush_slots", 64'(slot_full_o), 64'(3'b011));
    flush_i = 1'b1;
    set_src(0, 32'h77);
    tick();
    chk("flush_level", 64'(fifo_level_o), 64'(0));
    chk("flush_slots", 64'(slot_full_o), 64'(0));
    chk("flush_valid", 64'(trace_valid_o), 64'(0));
    chk("flush_drops", 64'(drop_count_o), 64'(1));
    chk("flush_ovf", 64'(overflow_o), 64'(1));

    restart();
    trace_ready_i = 1'b0;
    for (int v = 0; v < 30; v++) begin
      set_src(0, TW'(v));
      tick();
    end
    chk("sat_drops", 64'(drop_count_o), 64'(4'hF));
    chk("sat_ovf", 64'(overflow_o), 64'(1));

    restart();
    for (int c = 0; c < 800; c++) begin
      pct = (c < 400) ? 30 : 85;
      if ($urandom_range(0, 1) == 0) set_src(0, $urandom);
      if ($urandom_range(0, 1) == 0) set_src(1, $urandom);
      if ($urandom_range(0, 1) == 0) set_src(2, $urandom);
      trace_ready_i = ($urandom_range(0, 99) < pct);
      flush_i = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 150) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
